// File: rtl/chol_pkg.sv
// Shared Q16.16 constants, default divider latency and sequencer state encoding
// for the Cholesky column-divide path.
package chol_pkg;
    localparam int Q_W = 32;
    localparam int Q_FRAC = 16;
    localparam logic [Q_W-1:0] Q_ONE = 32'h0001_0000;
    localparam int DIV_LATENCY_DEF = 36;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PIVOT,
        ST_ISSUE,
        ST_DRAIN
    } state_t;
endpackage

// File: rtl/chol_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head entry is a register,
// so the read data is stable and resets to zero.
module chol_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // A write at full is accepted when the head leaves in the same cycle.
    assign do_rd = rd_en && (count != '0);
    assign do_wr = wr_en && ((count != CW'(DEPTH)) || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/chol_div_seq.sv
// Issue sequencer for the column divider: feeds pivot/dividend pairs, tracks
// the fixed divider latency and buffers tagged quotients with credit flow control.
module chol_div_seq
    import chol_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEF,
    parameter int FIFO_DEPTH  = 64,
    parameter int N_MAX       = 16,
    parameter int IDX_W       = $clog2(N_MAX)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IDX_W:0]     col_len,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [Q_W-1:0]     s_data,
    output logic               div_divisor_valid,
    output logic               div_dividend_valid,
    output logic [Q_W-1:0]     div_divisor,
    output logic [Q_W-1:0]     div_dividend,
    input  logic [Q_W-1:0]     div_out,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [Q_W-1:0]     m_data,
    output logic [IDX_W-1:0]   m_idx,
    output logic               busy,
    output logic               done,
    output logic               div0
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                              state;
    logic [IDX_W:0]                      len;
    logic [IDX_W-1:0]                    iss_idx;
    logic [IDX_W-1:0]                    div_idx;
    logic [IDX_W-1:0]                    last_idx;
    logic [Q_W-1:0]                      pivot;
    logic [CW-1:0]                       inflight;
    logic [CW-1:0]                       fifo_count;
    logic [CW:0]                         occupancy;
    logic                                credit_ok;
    logic                                s_fire;
    logic                                iss_fire;
    logic                                m_fire;
    logic [DIV_LATENCY-1:0]              sr_vld;
    logic [DIV_LATENCY-1:0][IDX_W-1:0]   sr_idx;
    logic                                pop;
    logic [Q_W-1:0]                      q_wr;
    logic [IDX_W+Q_W-1:0]                fifo_head;

    // Every accepted dividend holds one credit until its quotient leaves the FIFO.
    assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit_ok = occupancy < (CW+1)'(FIFO_DEPTH);
    assign s_ready   = (state == ST_PIVOT) || ((state == ST_ISSUE) && credit_ok);
    assign s_fire    = s_valid && s_ready;
    assign iss_fire  = s_fire && (state == ST_ISSUE);
    assign m_valid   = (fifo_count != '0);
    assign m_fire    = m_valid && m_ready;
    assign last_idx  = IDX_W'(len - 1'b1);
    assign pop       = sr_vld[DIV_LATENCY-1];
    assign q_wr      = div0 ? Q_W'(0) : div_out;
    assign m_data    = fifo_head[Q_W-1:0];
    assign m_idx     = fifo_head[IDX_W+Q_W-1:Q_W];

    // The divider has no valid output, so the tag pipeline stands in for one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_vld   <= '0;
            sr_idx   <= '0;
            inflight <= '0;
        end else begin
            sr_vld <= {sr_vld[DIV_LATENCY-2:0], div_divisor_valid};
            sr_idx <= {sr_idx[DIV_LATENCY-2:0], div_idx};
            case ({iss_fire, pop})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            len                <= '0;
            iss_idx            <= '0;
            div_idx            <= '0;
            pivot              <= '0;
            div0               <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            div_divisor_valid  <= 1'b0;
            div_dividend_valid <= 1'b0;
            div_divisor        <= '0;
            div_dividend       <= '0;
        end else begin
            done               <= 1'b0;
            div_divisor_valid  <= 1'b0;
            div_dividend_valid <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    len     <= (col_len == '0) ? (IDX_W+1)'(1) : col_len;
                    iss_idx <= '0;
                    div0    <= 1'b0;
                    busy    <= 1'b1;
                    state   <= ST_PIVOT;
                end
                ST_PIVOT: if (s_fire) begin
                    pivot <= s_data;
                    div0  <= (s_data == '0);
                    state <= ST_ISSUE;
                end
                ST_ISSUE: if (s_fire) begin
                    div_divisor_valid  <= 1'b1;
                    div_dividend_valid <= 1'b1;
                    div_divisor        <= pivot;
                    div_dividend       <= s_data;
                    div_idx            <= iss_idx;
                    iss_idx            <= iss_idx + 1'b1;
                    if (iss_idx == last_idx) state <= ST_DRAIN;
                end
                ST_DRAIN: if (m_fire && (m_idx == last_idx)) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    chol_sync_fifo #(
        .WIDTH(IDX_W + Q_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (pop),
        .wr_data({sr_idx[DIV_LATENCY-1], q_wr}),
        .rd_en  (m_fire),
        .rd_data(fifo_head),
        .count  (fifo_count)
    );
endmodule

// File: tb/tb_chol_div_seq.sv
// Directed/randomised bench for chol_div_seq with a fixed-latency divider model
// and an arithmetic quotient reference.
module tb_chol_div_seq;
    localparam int DL = 5;
    localparam int FD = 8;
    localparam int NM = 16;
    localparam int IW = 4;
    localparam int LIM = 3000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [IW:0]   col_len;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic          div_divisor_valid;
    logic          div_dividend_valid;
    logic [31:0]   div_divisor;
    logic [31:0]   div_dividend;
    logic [31:0]   div_out;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic [IW-1:0] m_idx;
    logic          busy;
    logic          done;
    logic          div0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int iss_cnt = 0;
    logic [31:0]   got_d[$];
    logic [IW-1:0] got_i[$];
    int            got_c[$];
    int            iss_c[$];
    logic [31:0]   dv[NM];
    logic [31:0]   qline[DL];

    chol_div_seq #(.DIV_LATENCY(DL), .FIFO_DEPTH(FD), .N_MAX(NM), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .col_len(col_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .div_divisor_valid(div_divisor_valid), .div_dividend_valid(div_dividend_valid),
        .div_divisor(div_divisor), .div_dividend(div_dividend), .div_out(div_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
        .busy(busy), .done(done), .div0(div0)
    );

    always #5 clk = ~clk;

    // Reference quotient: Q16.16 truncating divide; zero pivot yields zero.
    function automatic logic [31:0] qref(input logic [31:0] p, input logic [31:0] d);
        longint num;
        longint den;
        if (p == 32'h0) return 32'h0;
        num = longint'($signed(d)) * 65536;
        den = longint'($signed(p));
        return 32'(num / den);
    endfunction

    // Divider model: fixed latency, saturating garbage on divide-by-zero.
    always @(posedge clk) begin
        for (int k = DL - 1; k > 0; k--) qline[k] <= qline[k-1];
        if (div_divisor_valid && div_dividend_valid)
            qline[0] <= (div_divisor == 32'h0) ? 32'h7FFF_FFFF : qref(div_divisor, div_dividend);
        else
            qline[0] <= $urandom;
    end
    assign div_out = qline[DL-1];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_i.push_back(m_idx);
            got_c.push_back(cyc);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (div_divisor_valid) begin
            iss_cnt <= iss_cnt + 1;
            iss_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (t < LIM) begin
            @(negedge clk);
            if (s_ready) break;
            t++;
        end
        checks++;
        assert (t < LIM) else begin
            failures++;
            $error("FAIL s_ready_wait observed=%0d expected=<%0d", t, LIM);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_pivot();
        logic [31:0] p;
        p = $urandom_range(32'h7FFF_FFFF, 32'h0001_0000);
        if ($urandom_range(1, 0) == 1) p = -p;
        return p;
    endfunction

    // Runs one column; caller sits just after a rising edge.
    task automatic run_col(input int n, input logic [31:0] piv, input int hold, input bit b2b);
        int neff = (n == 0) ? 1 : n;
        int gb = got_d.size();
        int db = done_cnt;
        int ib = iss_cnt;
        int ibc = iss_c.size();
        int t = 0;
        start   = 1'b1;
        col_len = (IW+1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_rise", busy, 1);
        chk("div0_clear", div0, 0);
        @(posedge clk); #1;
        m_ready = (hold == 0);
        fork
            begin
                send(piv);
                for (int i = 0; i < neff; i++) begin
                    if (b2b && i == neff / 2) start = 1'b1;
                    send(dv[i]);
                    start = 1'b0;
                end
            end
            begin
                if (hold > 0) begin
                    repeat (hold) @(posedge clk);
                    @(negedge clk);
                    chk("bp_issued", iss_cnt - ib, (neff < FD) ? neff : FD);
                    chk("bp_s_ready", s_ready, (neff <= FD) ? 0 : 0);
                    chk("bp_m_valid", m_valid, 1);
                    chk("bp_none_out", got_d.size() - gb, 0);
                    @(posedge clk); #1;
                    m_ready = 1'b1;
                end
            end
        join
        @(negedge clk);
        while (!done && t < LIM) begin
            @(negedge clk);
            t++;
        end
        checks++;
        assert (t < LIM) else begin
            failures++;
            $error("FAIL done_wait observed=%0d expected=<%0d", t, LIM);
        end
        chk("busy_fall", busy, 0);
        chk("div0_flag", div0, (piv == 32'h0));
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt - db, 1);
        chk("res_count", got_d.size() - gb, neff);
        for (int i = 0; i < neff && gb + i < got_d.size(); i++) begin
            chk("res_idx", got_i[gb+i], i);
            chk("res_data", got_d[gb+i], qref(piv, dv[i]));
        end
        if (b2b && got_c.size() >= gb + neff && iss_c.size() >= ibc + neff) begin
            chk("b2b_issue_span", iss_c[ibc+neff-1] - iss_c[ibc], neff - 1);
            chk("b2b_result_span", got_c[gb+neff-1] - got_c[gb], neff - 1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int gb;
        rst_n = 1'b0; start = 1'b0; col_len = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div0", div0, 0);
        chk("rst_div_valid", {div_divisor_valid, div_dividend_valid}, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_idx", m_idx, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Basic column with hand-computed quotients
        dv[0] = 32'h0001_0000; dv[1] = 32'h0003_0000; dv[2] = 32'hFFF8_0000;
        gb = got_d.size();
        run_col(3, 32'h0002_0000, 0, 0);
        chk("basic_q0", got_d[gb], 32'h0000_8000);
        chk("basic_q1", got_d[gb+1], 32'h0001_8000);
        chk("basic_q2", got_d[gb+2], 32'hFFFC_0000);

        // Zero pivot: results forced to zero, flag sticky until next start
        for (int i = 0; i < NM; i++) dv[i] = $urandom;
        run_col(4, 32'h0, 0, 0);
        repeat (5) @(posedge clk); #1;
        @(negedge clk);
        chk("div0_sticky", div0, 1);
        @(posedge clk); #1;

        // col_len 0 behaves as 1
        run_col(0, rand_pivot(), 0, 0);

        // Backpressure with a full-length column
        for (int i = 0; i < NM; i++) dv[i] = $urandom;
        run_col(16, rand_pivot(), 200, 0);

        // Back-to-back full rate with an ignored mid-column start
        for (int i = 0; i < NM; i++) dv[i] = $urandom;
        run_col(16, rand_pivot(), 0, 1);

        // Reset with five operations in flight
        for (int i = 0; i < NM; i++) dv[i] = $urandom;
        m_ready = 1'b1;
        gb = got_d.size();
        start = 1'b1; col_len = (IW+1)'(8);
        @(posedge clk); #1;
        start = 1'b0;
        send(rand_pivot());
        for (int i = 0; i < 5; i++) send(dv[i]);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_rst_no_stale", got_d.size() - gb, 0);
        @(posedge clk); #1;
        for (int i = 0; i < NM; i++) dv[i] = $urandom;
        run_col(6, rand_pivot(), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/chol_div_seq.md
# chol_div_seq

Issue-side sequencer for the Cholesky column divider. It accepts one pivot (the diagonal element L(j,j)) and a stream of sub-diagonal dividends for column j. It drives the divider's divisor/dividend ports and tracks in-flight operations against the fixed divider latency, since the divider has no output valid. Quotients are buffered into an output stream tagged with row index. The block sits between the column-update engine and the `chol_div` instance, and owns all flow control, because the divider cannot be stalled per operation.

## Interface
- `DIV_LATENCY`, 36: cycles from `div_*_valid` high to the matching `div_out` being valid (divider core plus correction stage).
- `FIFO_DEPTH`, 64: result buffer entries; must be ≥ 2; power of two.
- `N_MAX`, 16: maximum dividends per column.
- `IDX_W`, $clog2(N_MAX): row-index width.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; latches `col_len` and begins a column.
- `col_len`  in  IDX_W+1  dividends in this column, 1..N_MAX; 0 is treated as 1.
- `s_valid`, `s_ready`  in/out  1  stream handshake, shared by the pivot beat and the dividend beats.
- `s_data`  in  32  signed Q16.16 operand: first beat after `start` is the pivot, the rest are dividends.
- `div_divisor_valid`, `div_dividend_valid`  out  1  to divider; always asserted together.
- `div_divisor`, `div_dividend`  out  32  to divider.
- `div_out`  in  32  signed Q16.16 quotient from divider.
- `m_valid`, `m_ready`  out/in  1  result stream handshake.
- `m_data`  out  32  quotient.
- `m_idx`  out  IDX_W  row index, 0-based within column.
- `busy`  out  1  high from `start` until `done`.
- `done`  out  1  one-cycle pulse after last result leaves on `m_*`.
- `div0`  out  1  sticky; pivot was zero; cleared by next `start`.

## Operation
- States: IDLE → PIVOT → ISSUE → DRAIN → IDLE.
  - IDLE: `s_ready`=0; `start` → PIVOT, latches length and clears counters and `div0`.
  - PIVOT: `s_ready`=1; on a handshake, registers the pivot, sets `div0` if it equals 0, then → ISSUE.
  - ISSUE: `s_ready` = credit_ok. Each handshake drives both `div_*_valid` high for exactly one cycle with the pivot and the dividend, and increments the issue index. After dividend `col_len`-1 is accepted → DRAIN.
  - DRAIN: `s_ready`=0; on the last result handshake on `m_*`, pulse `done` and → IDLE.
- Credit rule: credit_ok = (inflight + fifo_count) < FIFO_DEPTH. The buffer can therefore never overflow, whatever `m_ready` does.
- Latency tracking:
  - DIV_LATENCY-deep shift register of {valid, idx}.
  - An entry pushed on issue emerges DIV_LATENCY cycles later and writes {`div_out`, idx} into the FIFO.
  - `inflight` is the population count of the shift register, kept as an up/down counter. A simultaneous push and pop leaves it unchanged.
- Zero pivot: operations still issue so the latency and count bookkeeping is unchanged. The FIFO writes 0x00000000 instead of `div_out`.
- `start` while `busy` is ignored.
- `m_data`/`m_idx` are driven from the FIFO head; FIFO read on `m_valid & m_ready`. Simultaneous FIFO read and write at full or empty is legal.
- When idle, `div_divisor`/`div_dividend` hold their last values; `div_*_valid` are 0.

## Timing
- Reset (async assert, sync deassert assumed upstream):
  - state=IDLE.
  - All counters, the shift register and the FIFO pointers are 0.
  - `s_ready`, `div_*_valid`, `m_valid`, `busy`, `done` and `div0` are all 0.
  - `m_data`/`m_idx` are 0.
- Reset mid-column discards all in-flight results. Divider outputs arriving after reset are ignored because the shift register is cleared.
- Registered outputs: `div_*`, `m_*` (FIFO head register), `busy`, `done`.
- Latency: dividend accepted at cycle t → `div_*_valid` at t+1 → FIFO write at t+1+DIV_LATENCY → `m_valid` at t+2+DIV_LATENCY at the earliest.
- Throughput: one division per cycle while credit allows.
- `busy` rises the cycle after `start`. `done` coincides with `busy` falling.

## Structure
- Shared package `chol_pkg` holds:
  - The Q16.16 width and fraction constants (32/16).
  - `Q_ONE` = 32'h0001_0000.
  - The default `DIV_LATENCY`.
  - The state enum.
- Sub-module `chol_sync_fifo` (parameterised width/depth, count output) holds the result buffer. The latency shift register and FSM stay in the top.

## Test plan
- Basic column:
  - Stimulus: pivot 0x00020000; dividends 0x00010000, 0x00030000, 0xFFF80000.
  - Required: `m_data` 0x00008000, 0x00018000, 0xFFFC0000 with idx 0, 1, 2 (the bench divider model has latency DIV_LATENCY).
  - Required: `done` pulses once, `div0`=0.
- Backpressure:
  - Stimulus: FIFO_DEPTH=8, col_len=16, `m_ready` held 0 for 200 cycles, then 1.
  - Required: `s_ready` drops once inflight+count reaches 8, with no lost or duplicated results.
  - Required: all 16 results arrive in order.
- Zero pivot:
  - Stimulus: pivot 0, 4 dividends.
  - Required: four results of 0x00000000; `div0`=1 until the next `start`.
- Back-to-back:
  - Stimulus: full-rate stream with `m_ready`=1 and FIFO_DEPTH ≥ DIV_LATENCY+2.
  - Required: `div_*_valid` high on consecutive cycles and results spaced one per cycle.
  - Required: `start` pulsed mid-column is ignored.
- Reset mid-column:
  - Stimulus: assert `rst_n`=0 while 5 operations are in flight, then start a new column.
  - Required: none of the stale quotients appear; the new column's idx starts at 0.
- col_len=0:
  - Required: treated as 1, giving one result and `done`.
